rsnn_host_driver: RTL and testbench
===================================

Name: rsnn_host_driver

Overview:
Host-side stimulus engine for the RSNN tile pin interface. It is the initiator that drives the tile's ui_in/uio_in/ena pins and reads its uo_out pins back. Commands arrive on a valid/ready stream and are turned into correctly timed pin sequences: data write, parameter load, or timed inference run. Each run produces one response byte on a valid/ready output stream. The block sits between a host FIFO/CPU bridge and the tt_um RSNN top.

Parameters:
HOLD_CYCLES, 2, cycles a write/load strobe is held high (1..15)
RUN_CYCLES, 20, cycles the RSNN enable is held high during a run (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=NOP, 1=DATA_WRITE, 2=PARAM_LOAD, 3=RUN
cmd_data  in  8  payload byte for ops 1/2; ignored otherwise
pin_ena  out  1  to tile ena
pin_ui  out  8  to tile ui_in; [4]=rsnn_en, [5]=data_wr, [6]=param_ld, others 0
pin_uio  out  8  to tile uio_in (payload)
pin_uo  in  8  from tile uo_out
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  8  run result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate) sets all outputs to 0 and the state to IDLE. This includes pin_ena, pin_ui, pin_uio, rsp_valid and rsp_data. Reset mid-sequence aborts it and drops any pending response.
- States: IDLE, SETUP, STROBE, RECOVER, RUN, REPORT.
- IDLE: cmd_ready=1 and pin_ena=0. A handshake routes the command as follows:
  - op 0: consumed; no state change.
  - op 1/2: latch cmd_data into pin_uio and go to SETUP.
  - op 3: clear the result accumulator and go to RUN.
- SETUP (1 cycle): pin_ena=1, pin_uio=payload, all strobes 0. Next state is STROBE.
- STROBE (HOLD_CYCLES cycles): pin_ena=1 plus pin_ui[5] (op1) or pin_ui[6] (op2); payload stays stable. Next state is RECOVER.
- RECOVER (1 cycle): strobes 0, pin_ena=1. Next state is IDLE.
- Write/load latency from accept to IDLE is HOLD_CYCLES+2 cycles.
- RUN (RUN_CYCLES cycles): pin_ena=1, pin_ui[4]=1, pin_uio=0. Every cycle, pin_uo is sampled and OR-accumulated into the accumulator. Next state is REPORT.
- REPORT: rsp_valid=1 and rsp_data=accumulator, both held stable until rsp_ready. On handshake: rsp_valid=0 and go to IDLE the next cycle. pin_ena=0 in REPORT.
- cmd_ready is 0 in every state except IDLE. Commands are never dropped or reordered.
- Phase counter is 8 bits and loads its terminal count at each state entry. HOLD_CYCLES=0 is illegal and is flagged by an elaboration check.
- rsp_valid is asserted the cycle after the last RUN sample. A rsp_ready that is already high completes the handshake in that same cycle.

Optional Feature:
Macro RSNN_HOST_SPIKECOUNT_EN.
- Defined: rsp_data is a saturating count (max 255) of RUN cycles in which pin_uo != 0, instead of the OR accumulation.
- Undefined: OR accumulation as above; no counter logic is synthesised.

Test Plan:
- Reset: assert rst mid-STROBE of a write of 0x55. All pins go to 0 immediately. After release the block is in IDLE, busy=0, cmd_ready=1.
- DATA_WRITE 0xAA, HOLD_CYCLES=2:
  - pin_uio=0xAA for 4 cycles.
  - pin_ui=0x20 exactly 2 cycles, preceded and followed by 1 cycle of 0x00 with pin_ena=1.
  - cmd_ready returns after 4 cycles.
- PARAM_LOAD 0x11 immediately followed by DATA_WRITE 0xFF (cmd_valid held):
  - Second command is accepted only in IDLE.
  - pin_ui shows 0x40 for 2 cycles, then later 0x20 for 2 cycles; no overlap.
- RUN, RUN_CYCLES=20, tile model drives pin_uo=0x01 on cycle 3 and 0x80 on cycle 17:
  - pin_ui=0x10 for 20 cycles.
  - rsp_data=0x81.
  - With RSNN_HOST_SPIKECOUNT_EN defined, rsp_data=0x02.
- Backpressure: hold rsp_ready=0 for 10 cycles after a RUN. rsp_valid and rsp_data stay stable, cmd_ready=0, pin_ena=0. Raising rsp_ready completes the handshake and returns the block to IDLE.
- NOP command: consumed in 1 cycle, no pin activity, no response.

Source files
------------

// File: rtl/rsnn_host_driver.sv
// rsnn_host_driver: host-side pin sequencer for the RSNN tile.
// Turns DATA_WRITE / PARAM_LOAD / RUN commands into timed ena/ui/uio pin
// sequences and returns one result byte per RUN on a valid/ready stream.
// Optional macro RSNN_HOST_SPIKECOUNT_EN: the RUN result becomes a saturating
// count of cycles with any uo bit set instead of the OR of all uo samples.
module rsnn_host_driver #(
    parameter int HOLD_CYCLES = 2,
    parameter int RUN_CYCLES  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       pin_ena,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    input  logic [7:0] pin_uo,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
            $error("rsnn_host_driver: HOLD_CYCLES must be in 1..15");
        end
        if (RUN_CYCLES < 1 || RUN_CYCLES > 255) begin : g_bad_run
            $error("rsnn_host_driver: RUN_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_TC = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RUN_TC  = 8'(RUN_CYCLES - 1);

    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, RUN, REPORT} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;   // phase counter, counts down to 0
    logic [1:0] op;             // op of the write/load in flight
    logic [7:0] payload;
    logic [7:0] acc;            // RUN result accumulator
    logic       cmd_fire;

    assign cmd_fire = cmd_valid && cmd_ready;

    // State, phase counter, latched command and result accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            op      <= 2'd0;
            payload <= 8'd0;
            acc     <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cmd_fire && (cmd_op == OP_WRITE || cmd_op == OP_LOAD)) begin
                op      <= cmd_op;
                payload <= cmd_data;
            end
            if (cmd_fire && cmd_op == OP_RUN) begin
                acc <= 8'd0;
            end else if (state == RUN) begin
`ifdef RSNN_HOST_SPIKECOUNT_EN
                if (pin_uo != 8'd0 && acc != 8'hFF) acc <= acc + 8'd1;
`else
                acc <= acc | pin_uo;
`endif
            end
        end
    end

    // Next-state, counter reload on state entry, and pin/stream outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_ready = 1'b0;
        pin_ena   = 1'b0;
        pin_ui    = 8'd0;
        pin_uio   = 8'd0;
        rsp_valid = 1'b0;
        rsp_data  = 8'd0;
        case (state)
            IDLE: begin
                // held low while reset is asserted so every output reads 0
                cmd_ready = !rst;
                if (cmd_fire) begin
                    if (cmd_op == OP_WRITE || cmd_op == OP_LOAD) begin
                        state_nxt = SETUP;
                    end else if (cmd_op == OP_RUN) begin
                        state_nxt = RUN;
                        cnt_nxt   = RUN_TC;
                    end
                end
            end
            SETUP: begin
                pin_ena   = 1'b1;
                pin_uio   = payload;
                state_nxt = STROBE;
                cnt_nxt   = HOLD_TC;
            end
            STROBE: begin
                pin_ena   = 1'b1;
                pin_uio   = payload;
                pin_ui[5] = (op == OP_WRITE);
                pin_ui[6] = (op == OP_LOAD);
                if (cnt == 8'd0) state_nxt = RECOVER;
                else             cnt_nxt   = cnt - 8'd1;
            end
            RECOVER: begin
                pin_ena   = 1'b1;
                pin_uio   = payload;
                state_nxt = IDLE;
            end
            RUN: begin
                pin_ena   = 1'b1;
                pin_ui[4] = 1'b1;
                if (cnt == 8'd0) state_nxt = REPORT;
                else             cnt_nxt   = cnt - 8'd1;
            end
            REPORT: begin
                rsp_valid = 1'b1;
                rsp_data  = acc;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rsnn_host_driver.sv
// tb_rsnn_host_driver: directed scenarios with a response scoreboard.
module tb_rsnn_host_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       pin_ena;
    logic [7:0] pin_ui;
    logic [7:0] pin_uio;
    logic [7:0] pin_uo = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    rsnn_host_driver #(.HOLD_CYCLES(2), .RUN_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .pin_ena(pin_ena), .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #2;
        checks++;
        if ({pin_ena, pin_ui, pin_uio, rsp_valid, rsp_data, cmd_ready} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0",
                {pin_ena, pin_ui, pin_uio, rsp_valid, rsp_data, cmd_ready});
        end
        @(negedge clk); rst = 1'b0;
        // start a write of 0x55 and abort it mid-STROBE
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h55;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); // SETUP
        @(negedge clk); // STROBE
        checks++;
        if (pin_ui !== 8'h20 || pin_uio !== 8'h55) begin
            errors++; $display("FAIL reset_pre_strobe: ui=%h uio=%h want 20/55", pin_ui, pin_uio);
        end
        rst = 1'b1; #1;
        checks++;
        if (pin_ena !== 1'b0 || pin_ui !== 8'h00 || pin_uio !== 8'h00 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async: ena=%b ui=%h uio=%h rv=%b want 0",
                pin_ena, pin_ui, pin_uio, rsp_valid);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || pin_ena !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b ready=%b ena=%b want 0/1/0",
                busy, cmd_ready, pin_ena);
        end
    endtask

    task automatic test_write(input logic [7:0] d);
        logic [7:0] eui;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = d;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL write_ready: got %b want 1", cmd_ready);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            eui = (k == 2 || k == 3) ? 8'h20 : 8'h00;
            checks++;
            if (pin_ena !== 1'b1 || pin_ui !== eui || pin_uio !== d || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL write_seq[%0d]: ena=%b ui=%h uio=%h rdy=%b want 1/%h/%h/0",
                    k, pin_ena, pin_ui, pin_uio, cmd_ready, eui, d);
            end
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || pin_ena !== 1'b0 || pin_uio !== 8'h00 || pin_ui !== 8'h00) begin
            errors++; $display("FAIL write_done: rdy=%b ena=%b uio=%h ui=%h want 1/0/00/00",
                cmd_ready, pin_ena, pin_uio, pin_ui);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ui_tr[16];
        logic [7:0] uio_tr[16];
        int acc_idx[2];
        int n_acc = 0;
        int n40 = 0, n20 = 0, last40 = -1, first20 = 99;
        bit fire;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'h11;
        for (int k = 0; k < 16; k++) begin
            ui_tr[k] = pin_ui; uio_tr[k] = pin_uio;
            fire = cmd_valid && cmd_ready;
            if (fire) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL b2b_accept_busy: busy=%b at %0d want 0", busy, k);
                end
                if (n_acc < 2) acc_idx[n_acc] = k;
                n_acc++;
            end
            @(posedge clk); #1;
            if (fire) begin
                if (n_acc == 1) begin cmd_op = 2'd1; cmd_data = 8'hFF; end
                else cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 16; k++) begin
            if (ui_tr[k] == 8'h40) begin
                n40++; last40 = k;
                checks++;
                if (uio_tr[k] !== 8'h11) begin
                    errors++; $display("FAIL b2b_load_payload: got %h want 11", uio_tr[k]);
                end
            end
            if (ui_tr[k] == 8'h20) begin
                n20++; if (k < first20) first20 = k;
                checks++;
                if (uio_tr[k] !== 8'hFF) begin
                    errors++; $display("FAIL b2b_write_payload: got %h want ff", uio_tr[k]);
                end
            end
        end
        checks++;
        if (n_acc !== 2 || n40 !== 2 || n20 !== 2 || last40 >= first20) begin
            errors++; $display("FAIL b2b_strobes: acc=%0d n40=%0d n20=%0d last40=%0d first20=%0d want 2/2/2/ordered",
                n_acc, n40, n20, last40, first20);
        end
        checks++;
        if (n_acc >= 2 && (acc_idx[0] !== 0 || acc_idx[1] !== 5)) begin
            errors++; $display("FAIL b2b_accept_time: %0d,%0d want 0,5", acc_idx[0], acc_idx[1]);
        end
    endtask

    // RUN with two tile pulses; bp_cycles>0 holds rsp_ready low that long
    task automatic test_run(input int c1, input logic [7:0] v1, input int c2,
                            input logic [7:0] v2, input int bp_cycles);
        logic [7:0] e_or = 8'h00;
        logic [7:0] e_cnt = 8'h00;
        logic [7:0] uo;
        logic [7:0] exp;
        bit got = 0;
        for (int i = 1; i <= 20; i++) begin
            uo = (i == c1) ? v1 : (i == c2) ? v2 : 8'h00;
            e_or |= uo;
            if (uo != 8'h00) e_cnt++;
        end
`ifdef RSNN_HOST_SPIKECOUNT_EN
        exp_q.push_back(e_cnt);
`else
        exp_q.push_back(e_or);
`endif
        rsp_ready = (bp_cycles == 0);
        pin_uo = 8'h04; // idle-time noise must not reach the result
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 8'h5A;
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            pin_uo = (i == c1) ? v1 : (i == c2) ? v2 : 8'h00;
            checks++;
            if (pin_ui !== 8'h10 || pin_ena !== 1'b1 || pin_uio !== 8'h00 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL run_pins[%0d]: ui=%h ena=%b uio=%h rv=%b want 10/1/00/0",
                    i, pin_ui, pin_ena, pin_uio, rsp_valid);
            end
        end
        @(negedge clk);
        pin_uo = 8'h00;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL run_rsp_latency: rsp_valid=%b want 1", rsp_valid);
        end
        for (int j = 0; j < bp_cycles; j++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0] || cmd_ready !== 1'b0 || pin_ena !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: rv=%b data=%h rdy=%b ena=%b want 1/%h/0/0",
                    j, rsp_valid, rsp_data, cmd_ready, pin_ena, exp_q[0]);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            if (rsp_valid && rsp_ready) begin
                exp = exp_q.pop_front();
                got = 1;
                checks++;
                if (rsp_data !== exp) begin
                    errors++; $display("FAIL run_rsp_data: got %h want %h", rsp_data, exp);
                end
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL run_rsp_timeout: no response within 50 cycles");
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL run_back_idle: rv=%b rdy=%b busy=%b want 0/1/0",
                rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_nop();
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'hC3;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL nop_ready: got %b want 1", cmd_ready);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pin_ena !== 1'b0 || pin_ui !== 8'h00 || pin_uio !== 8'h00 ||
                rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL nop_quiet[%0d]: busy=%b ena=%b ui=%h uio=%h rv=%b rdy=%b",
                    k, busy, pin_ena, pin_ui, pin_uio, rsp_valid, cmd_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_write(8'hAA);
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_run(3, 8'h01, 17, 8'h80, 0);
        test_run(1, 8'h02, 20, 8'h40, 10);
        test_nop();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
